// File: rtl/fli_arb.sv
// fli_arb: two-requester Zfa "fli" immediate generator feeding a 2-entry result FIFO.
// Optional feature: define FLI_ARB_RR_EN for round-robin arbitration between the
// requesters; the default build uses fixed priority with requester 0 first.
module fli_arb #(
  parameter int FLEN    = 64,
  parameter int FMTBITS = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               Req0Valid,
  output logic               Req0Ready,
  input  logic [4:0]         Req0Rs1,
  input  logic [FMTBITS-1:0] Req0Fmt,
  input  logic               Req1Valid,
  output logic               Req1Ready,
  input  logic [4:0]         Req1Rs1,
  input  logic [FMTBITS-1:0] Req1Fmt,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [FLEN-1:0]    OutImm,
  output logic               OutSrc,
  output logic               OutErr
);

  // FIFO entry layout: {err, src, imm}
  localparam int EW = FLEN + 2;

  // Zfa constant for (rs1, fmt), NaN-boxed with ones up to 128 bits, cut to FLEN.
  // Normal entries are 2^e * (1 + m/4); the few irregular entries are spelled out.
  function automatic logic [FLEN-1:0] fli_lookup(input logic [4:0] rs1, input logic [1:0] fmt);
    logic [127:0]       res;
    logic               sgn;
    logic signed [15:0] e;
    logic [1:0]         m;
    logic [4:0]         be5;
    logic [7:0]         be8;
    logic [10:0]        be11;
    logic [14:0]        be15;
    res = {128{1'b1}};
    sgn = 1'b0;
    e   = 16'sd0;
    m   = 2'd0;
    case (rs1)
      5'd0:  sgn = 1'b1;                       // -1.0
      5'd2:  e = -16'sd16;
      5'd3:  e = -16'sd15;
      5'd4:  e = -16'sd8;
      5'd5:  e = -16'sd7;
      5'd6:  e = -16'sd4;
      5'd7:  e = -16'sd3;
      5'd8:  e = -16'sd2;
      5'd9:  begin e = -16'sd2; m = 2'd1; end
      5'd10: begin e = -16'sd2; m = 2'd2; end
      5'd11: begin e = -16'sd2; m = 2'd3; end
      5'd12: e = -16'sd1;
      5'd13: begin e = -16'sd1; m = 2'd1; end
      5'd14: begin e = -16'sd1; m = 2'd2; end
      5'd15: begin e = -16'sd1; m = 2'd3; end
      5'd16: e = 16'sd0;
      5'd17: m = 2'd1;
      5'd18: m = 2'd2;
      5'd19: m = 2'd3;
      5'd20: e = 16'sd1;
      5'd21: begin e = 16'sd1; m = 2'd1; end
      5'd22: begin e = 16'sd1; m = 2'd2; end
      5'd23: e = 16'sd2;
      5'd24: e = 16'sd3;
      5'd25: e = 16'sd4;
      5'd26: e = 16'sd7;
      5'd27: e = 16'sd8;
      5'd28: e = 16'sd15;
      5'd29: e = 16'sd16;
      default: begin sgn = 1'b0; e = 16'sd0; m = 2'd0; end  // 1, 30, 31 special below
    endcase
    be5  = 5'(e + 16'sd15);
    be8  = 8'(e + 16'sd127);
    be11 = 11'(e + 16'sd1023);
    be15 = 15'(e + 16'sd16383);
    case (fmt)
      2'b00: begin
        case (rs1)
          5'd1:    res[31:0] = 32'h0080_0000;
          5'd30:   res[31:0] = 32'h7F80_0000;
          5'd31:   res[31:0] = 32'h7FC0_0000;
          default: res[31:0] = {sgn, be8, m, 21'd0};
        endcase
      end
      2'b01: begin
        case (rs1)
          5'd1:    res[63:0] = 64'h0010_0000_0000_0000;
          5'd30:   res[63:0] = 64'h7FF0_0000_0000_0000;
          5'd31:   res[63:0] = 64'h7FF8_0000_0000_0000;
          default: res[63:0] = {sgn, be11, m, 50'd0};
        endcase
      end
      2'b10: begin
        // 2^-16 and 2^-15 are subnormal in half; 2^16 overflows to +inf
        case (rs1)
          5'd1:    res[15:0] = 16'h0400;
          5'd2:    res[15:0] = 16'h0100;
          5'd3:    res[15:0] = 16'h0200;
          5'd29:   res[15:0] = 16'h7C00;
          5'd30:   res[15:0] = 16'h7C00;
          5'd31:   res[15:0] = 16'h7E00;
          default: res[15:0] = {sgn, be5, m, 8'd0};
        endcase
      end
      default: begin
        case (rs1)
          5'd1:    res = {1'b0, 15'd1, 112'd0};
          5'd30:   res = {1'b0, 15'h7FFF, 112'd0};
          5'd31:   res = {1'b0, 15'h7FFF, 1'b1, 111'd0};
          default: res = {sgn, be15, m, 110'd0};
        endcase
      end
    endcase
    return res[FLEN-1:0];
  endfunction

  // Format is wider than the register file can hold.
  function automatic logic fmt_too_wide(input logic [1:0] fmt);
    case (fmt)
      2'b01:   return (FLEN < 64) ? 1'b1 : 1'b0;
      2'b11:   return (FLEN < 128) ? 1'b1 : 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic [EW-1:0] mem_q [2];
  logic [EW-1:0] mem_d [2];
  logic          grant0_s, grant1_s, push_s, pop_s, sel_s, err_s;
  logic [4:0]    sel_rs1_s;
  logic [1:0]    sel_fmt_s;
  logic [EW-1:0] new_entry_s, head_s;

`ifdef FLI_ARB_RR_EN
  logic prio_q, prio_d;  // 1: requester 1 favoured on a tie

  // Round-robin grant: on a tie the requester not granted last wins.
  always_comb begin
    grant0_s = Req0Valid && (!Req1Valid || !prio_q);
    grant1_s = Req1Valid && (!Req0Valid || prio_q);
  end

  // Priority pointer moves only when a request is actually accepted.
  always_comb begin
    if (push_s) prio_d = ~sel_s;
    else        prio_d = prio_q;
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prio_q <= 1'b0;
    else          prio_q <= prio_d;
  end
`else
  // Fixed-priority grant: requester 0 always wins.
  always_comb begin
    grant0_s = Req0Valid;
    grant1_s = Req1Valid && !Req0Valid;
  end
`endif

  // Handshake and selection of the accepted request; never ready while full.
  always_comb begin
    Req0Ready   = reset_n && grant0_s && (count_q != 2'd2);
    Req1Ready   = reset_n && grant1_s && (count_q != 2'd2);
    push_s      = (Req0Valid && Req0Ready) || (Req1Valid && Req1Ready);
    pop_s       = OutValid && OutReady;
    sel_s       = grant1_s;
    sel_rs1_s   = sel_s ? Req1Rs1 : Req0Rs1;
    sel_fmt_s   = sel_s ? Req1Fmt[1:0] : Req0Fmt[1:0];
    err_s       = fmt_too_wide(sel_fmt_s);
    new_entry_s = {err_s, sel_s, err_s ? {FLEN{1'b0}} : fli_lookup(sel_rs1_s, sel_fmt_s)};
  end

  // FIFO next state: write at wr_ptr on push, advance rd_ptr on pop.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push_s) begin
      mem_d[wr_ptr_q] = new_entry_s;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) rd_ptr_d = ~rd_ptr_q;
    else       rd_ptr_d = rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset discards buffered entries immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

  // Head presentation; fields are zero whenever the FIFO is empty.
  always_comb begin
    OutValid = (count_q != 2'd0);
    head_s   = mem_q[rd_ptr_q];
    if (OutValid) begin
      OutErr = head_s[EW-1];
      OutSrc = head_s[EW-2];
      OutImm = head_s[FLEN-1:0];
    end else begin
      OutErr = 1'b0;
      OutSrc = 1'b0;
      OutImm = '0;
    end
  end

endmodule

// File: tb/tb_fli_arb.sv
// Self-checking bench for fli_arb (FLEN=64); the reference model computes the
// constants from their real values and keeps the FIFO as a queue.
module tb_fli_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid, out_ready;
  logic [4:0]  req0_rs1, req1_rs1;
  logic [1:0]  req0_fmt, req1_fmt;
  logic        Req0Ready, Req1Ready, OutValid, OutSrc, OutErr;
  logic [63:0] OutImm;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: entries are {err, src, imm}
  logic [65:0] m_q[$];
  int          last_grant = 1;

  fli_arb #(.FLEN(64), .FMTBITS(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .Req0Valid(req0_valid), .Req0Ready(Req0Ready), .Req0Rs1(req0_rs1), .Req0Fmt(req0_fmt),
    .Req1Valid(req1_valid), .Req1Ready(Req1Ready), .Req1Rs1(req1_rs1), .Req1Fmt(req1_fmt),
    .OutValid(OutValid), .OutReady(out_ready), .OutImm(OutImm), .OutSrc(OutSrc), .OutErr(OutErr)
  );

  always #5 clk = ~clk;

  function automatic real fli_val(input logic [4:0] i);
    case (i)
      5'd0:  return -1.0;
      5'd2:  return 1.0 / 65536.0;
      5'd3:  return 1.0 / 32768.0;
      5'd4:  return 1.0 / 256.0;
      5'd5:  return 1.0 / 128.0;
      5'd6:  return 0.0625;
      5'd7:  return 0.125;
      5'd8:  return 0.25;
      5'd9:  return 0.3125;
      5'd10: return 0.375;
      5'd11: return 0.4375;
      5'd12: return 0.5;
      5'd13: return 0.625;
      5'd14: return 0.75;
      5'd15: return 0.875;
      5'd16: return 1.0;
      5'd17: return 1.25;
      5'd18: return 1.5;
      5'd19: return 1.75;
      5'd20: return 2.0;
      5'd21: return 2.5;
      5'd22: return 3.0;
      5'd23: return 4.0;
      5'd24: return 8.0;
      5'd25: return 16.0;
      5'd26: return 128.0;
      5'd27: return 256.0;
      5'd28: return 32768.0;
      5'd29: return 65536.0;
      default: return 0.0;
    endcase
  endfunction

  // Expected {err, imm} for FLEN=64, derived from the IEEE double encoding.
  function automatic logic [64:0] exp_fli(input logic [4:0] rs1, input logic [1:0] fmt);
    logic [63:0] d;
    logic [7:0]  be8;
    logic [4:0]  be5;
    int          ex;
    int          mant;
    d   = $realtobits(fli_val(rs1));
    ex  = int'(d[62:52]) - 1023;
    be8 = 8'(ex + 127);
    be5 = 5'(ex + 15);
    case (fmt)
      2'b00: begin
        if (rs1 == 5'd1)       return {1'b0, 32'hFFFF_FFFF, 32'h0080_0000};
        else if (rs1 == 5'd30) return {1'b0, 32'hFFFF_FFFF, 32'h7F80_0000};
        else if (rs1 == 5'd31) return {1'b0, 32'hFFFF_FFFF, 32'h7FC0_0000};
        else                   return {1'b0, 32'hFFFF_FFFF, d[63], be8, d[51:29]};
      end
      2'b01: begin
        if (rs1 == 5'd1)       return {1'b0, 64'h0010_0000_0000_0000};
        else if (rs1 == 5'd30) return {1'b0, 64'h7FF0_0000_0000_0000};
        else if (rs1 == 5'd31) return {1'b0, 64'h7FF8_0000_0000_0000};
        else                   return {1'b0, d};
      end
      2'b10: begin
        if (rs1 == 5'd1) return {1'b0, 48'hFFFF_FFFF_FFFF, 16'h0400};
        else if (rs1 == 5'd2 || rs1 == 5'd3) begin
          mant = int'(fli_val(rs1) * 16777216.0);
          return {1'b0, 48'hFFFF_FFFF_FFFF, 16'(mant)};
        end
        else if (rs1 == 5'd29 || rs1 == 5'd30) return {1'b0, 48'hFFFF_FFFF_FFFF, 16'h7C00};
        else if (rs1 == 5'd31) return {1'b0, 48'hFFFF_FFFF_FFFF, 16'h7E00};
        else return {1'b0, 48'hFFFF_FFFF_FFFF, d[63], be5, d[51:42]};
      end
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  // Which requester the arbitration rules pick this cycle (-1: none).
  function automatic int m_winner();
    if (!req0_valid && !req1_valid) return -1;
    if (!req1_valid) return 0;
    if (!req0_valid) return 1;
`ifdef FLI_ARB_RR_EN
    return (last_grant == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Advance the model with the current inputs, then one clock.
  task automatic tick();
    int          w;
    logic        acc;
    logic [64:0] r;
    w   = m_winner();
    acc = (w >= 0) && (m_q.size() < 2);
    if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
    if (acc) begin
      r = (w == 0) ? exp_fli(req0_rs1, req0_fmt) : exp_fli(req1_rs1, req1_fmt);
      m_q.push_back({r[64], w[0], r[63:0]});
      last_grant = w;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
    req0_rs1 = 5'd0; req1_rs1 = 5'd0; req0_fmt = 2'b00; req1_fmt = 2'b00;
  endtask

  task automatic apply_reset();
    set_idle();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    m_q.delete();
    last_grant = 1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    #2;
    n_tests++; if (Req0Ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready: got %b want 0", Req0Ready); end
    n_tests++; if (Req1Ready !== 1'b0) begin n_fail++; $display("FAIL reset_req1_ready: got %b want 0", Req1Ready); end
    n_tests++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", OutValid); end
    n_tests++; if (OutImm !== 64'd0) begin n_fail++; $display("FAIL reset_out_imm: got %h want 0", OutImm); end
    n_tests++; if (OutSrc !== 1'b0 || OutErr !== 1'b0) begin n_fail++; $display("FAIL reset_src_err: got %b%b want 00", OutSrc, OutErr); end
    @(posedge clk);
    #1;
    n_tests++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid: got %b want 0", OutValid); end
    apply_reset();
  endtask

  task automatic test_values();
    set_idle(); out_ready = 1'b1;
    req0_valid = 1'b1; req0_rs1 = 5'd16; req0_fmt = 2'b01;
    #1;
    n_tests++; if (Req0Ready !== 1'b1) begin n_fail++; $display("FAIL val_ready: got %b want 1", Req0Ready); end
    tick(); req0_valid = 1'b0; #1;
    n_tests++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL val_latency: got %b want 1", OutValid); end
    n_tests++; if (OutImm !== 64'h3FF0_0000_0000_0000 || OutSrc !== 1'b0 || OutErr !== 1'b0)
      begin n_fail++; $display("FAIL val_one_d: got %h/%b/%b want 3ff0000000000000/0/0", OutImm, OutSrc, OutErr); end
    tick();
    req1_valid = 1'b1; req1_rs1 = 5'd31; req1_fmt = 2'b00;
    tick(); req1_valid = 1'b0; #1;
    n_tests++; if (OutImm !== 64'hFFFF_FFFF_7FC0_0000 || OutSrc !== 1'b1)
      begin n_fail++; $display("FAIL val_nan_s: got %h/%b want ffffffff7fc00000/1", OutImm, OutSrc); end
    tick();
    req1_valid = 1'b1; req1_rs1 = 5'd0; req1_fmt = 2'b10;
    tick(); req1_valid = 1'b0; #1;
    n_tests++; if (OutImm !== 64'hFFFF_FFFF_FFFF_BC00)
      begin n_fail++; $display("FAIL val_m1_h: got %h want ffffffffffffbc00", OutImm); end
    tick();
    req0_valid = 1'b1; req0_rs1 = 5'd20; req0_fmt = 2'b11;
    tick(); req0_valid = 1'b0; #1;
    n_tests++; if (OutImm !== 64'd0 || OutErr !== 1'b1)
      begin n_fail++; $display("FAIL val_quad_err: got %h/%b want 0/1", OutImm, OutErr); end
    tick();
  endtask

  task automatic test_arbitration();
    logic exp_src [4];
`ifdef FLI_ARB_RR_EN
    exp_src = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_src = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    apply_reset();
    out_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_rs1 = 5'($urandom_range(0, 31)); req1_rs1 = 5'($urandom_range(0, 31));
      req0_fmt = 2'($urandom_range(0, 2));  req1_fmt = 2'($urandom_range(0, 2));
      tick();
      n_tests++; if (OutSrc !== exp_src[i] || OutValid !== 1'b1)
        begin n_fail++; $display("FAIL arb_src[%0d]: got %b (valid %b) want %b", i, OutSrc, OutValid, exp_src[i]); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int          accepts;
    logic [64:0] want [2];
    logic [63:0] head;
    set_idle();
    accepts = 0;
    head = 64'd0;
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_rs1 = 5'($urandom_range(0, 31)); req0_fmt = 2'($urandom_range(0, 2));
      #1;
      if (Req0Ready === 1'b1) begin
        if (accepts < 2) want[accepts] = exp_fli(req0_rs1, req0_fmt);
        accepts++;
      end
      if (i == 1) head = OutImm;
      if (i >= 2) begin
        n_tests++; if (OutImm !== head) begin n_fail++; $display("FAIL bp_head_stable[%0d]: got %h want %h", i, OutImm, head); end
      end
      tick();
    end
    n_tests++; if (accepts !== 2) begin n_fail++; $display("FAIL bp_accepts: got %0d want 2", accepts); end
    out_ready = 1'b1;
    #1;
    n_tests++; if (Req0Ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_pop_ready: got %b want 0", Req0Ready); end
    n_tests++; if (OutImm !== want[0][63:0]) begin n_fail++; $display("FAIL bp_drain0: got %h want %h", OutImm, want[0][63:0]); end
    tick(); req0_valid = 1'b0; #1;
    n_tests++; if (OutImm !== want[1][63:0]) begin n_fail++; $display("FAIL bp_drain1: got %h want %h", OutImm, want[1][63:0]); end
    tick();
    n_tests++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", OutValid); end
  endtask

  task automatic test_async_reset();
    set_idle();
    req0_valid = 1'b1; req0_rs1 = 5'd18; req0_fmt = 2'b00;
    tick(); tick();
    #1;
    n_tests++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL ar_filled: got %b want 1", OutValid); end
    reset_n = 1'b0;
    #1;
    n_tests++; if (OutValid !== 1'b0 || Req0Ready !== 1'b0)
      begin n_fail++; $display("FAIL ar_async_clear: got valid %b ready %b want 0 0", OutValid, Req0Ready); end
    m_q.delete();
    last_grant = 1;
    reset_n = 1'b1;
    req1_valid = 1'b1; out_ready = 1'b1;
    tick();
    n_tests++; if (OutSrc !== 1'b0 || OutValid !== 1'b1)
      begin n_fail++; $display("FAIL ar_tie_after_reset: got src %b valid %b want 0 1", OutSrc, OutValid); end
    set_idle(); out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int   w;
    logic e0, e1;
    set_idle();
    for (int c = 0; c < 400; c++) begin
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_rs1 = 5'($urandom_range(0, 31));  req1_rs1 = 5'($urandom_range(0, 31));
      req0_fmt = 2'($urandom_range(0, 3));   req1_fmt = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      w  = m_winner();
      e0 = (w == 0) && (m_q.size() < 2);
      e1 = (w == 1) && (m_q.size() < 2);
      n_tests++; if (Req0Ready !== e0 || Req1Ready !== e1)
        begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", c, Req0Ready, Req1Ready, e0, e1); end
      n_tests++; if (OutValid !== (m_q.size() != 0))
        begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, OutValid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        n_tests++; if ({OutErr, OutSrc, OutImm} !== m_q[0])
          begin n_fail++; $display("FAIL rnd_head[%0d]: got %b/%b/%h want %b/%b/%h", c, OutErr, OutSrc, OutImm, m_q[0][65], m_q[0][64], m_q[0][63:0]); end
      end
      tick();
    end
  endtask

  initial begin
    set_idle();
    reset_n = 1'b0;
    test_reset();
    test_values();
    test_arbitration();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
